// File: rtl/laser_mon_pkg.sv
// laser_mon_pkg: shared types and constants for the laser pulse monitor.
package laser_mon_pkg;

    // FSM states of the pulse monitor
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        FAULT = 2'd2
    } laser_mon_state_t;

    // Width of the good/bad pulse event counters
    localparam int LASER_MON_CNT_W = 16;

endpackage

// File: rtl/laser_mon_sat_cnt.sv
// laser_mon_sat_cnt: NBITS unsigned up-counter that sticks at all-ones.
// Synchronous active-high reset and clear, count enable.
module laser_mon_sat_cnt #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [NBITS-1:0] o_count
);

    localparam logic [NBITS-1:0] MAX_VAL = '1;

    logic [NBITS-1:0] r_count;

    // Clear has priority over increment; increment stops at the maximum value
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + NBITS'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/laser_pulse_monitor.sv
// laser_pulse_monitor: measures every laser-on pulse on 'light', reports
// its length and tolerance status, counts good/bad pulses and requests a
// laser kill on overrun.
// Optional macro LASER_MON_STICKY_KILL_EN: when defined, an overrun latches
// the kill request until reset and the monitor ignores later pulses.
module laser_pulse_monitor
    import laser_mon_pkg::*;
#(
    parameter int NBITS        = 16,
    parameter int PULSE_CYCLES = 5,
    parameter int TOL          = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       light,
    output logic                       pulse_done,
    output logic [NBITS-1:0]           pulse_len,
    output logic                       len_ok,
    output logic                       laser_kill,
    output logic [LASER_MON_CNT_W-1:0] good_cnt,
    output logic [LASER_MON_CNT_W-1:0] bad_cnt
);

    localparam logic [NBITS-1:0] LEN_LO = NBITS'(PULSE_CYCLES - TOL);
    localparam logic [NBITS-1:0] LEN_HI = NBITS'(PULSE_CYCLES + TOL);

    laser_mon_state_t            r_state;
    logic                        r_pulseDone;
    logic [NBITS-1:0]            r_pulseLen;
    logic                        r_lenOk;
    logic                        r_laserKill;
    logic [LASER_MON_CNT_W-1:0]  r_goodCnt;
    logic [LASER_MON_CNT_W-1:0]  r_badCnt;
`ifdef LASER_MON_STICKY_KILL_EN
    logic                        r_faultReported;
`endif

    logic [NBITS-1:0]            w_cnt;
    logic                        w_lenInTol;

    // The pulse counter runs while light is high and is cleared by any low
    // sample, so it always reads 0 in IDLE and the first high sample gives 1.
    laser_mon_sat_cnt #(
        .NBITS (NBITS)
    ) u_pulseCnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (~light),
        .i_inc   (light),
        .o_count (w_cnt)
    );

    assign w_lenInTol = (w_cnt >= LEN_LO) && (w_cnt <= LEN_HI);

    // Pulse FSM with registered reports, kill request and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pulseDone <= 1'b0;
            r_pulseLen  <= '0;
            r_lenOk     <= 1'b0;
            r_laserKill <= 1'b0;
            r_goodCnt   <= '0;
            r_badCnt    <= '0;
`ifdef LASER_MON_STICKY_KILL_EN
            r_faultReported <= 1'b0;
`endif
        end else begin
            r_pulseDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (light) begin
                        r_state <= ON;
                    end
                end
                ON: begin
                    if (light) begin
                        if (w_cnt == LEN_HI) begin
                            r_state     <= FAULT;
                            r_laserKill <= 1'b1;
                        end
                    end else begin
                        r_pulseDone <= 1'b1;
                        r_pulseLen  <= w_cnt;
                        r_lenOk     <= w_lenInTol;
                        if (w_lenInTol) begin
                            r_goodCnt <= r_goodCnt + LASER_MON_CNT_W'(1);
                        end else begin
                            r_badCnt <= r_badCnt + LASER_MON_CNT_W'(1);
                        end
                        r_state <= IDLE;
                    end
                end
                FAULT: begin
`ifdef LASER_MON_STICKY_KILL_EN
                    if (!light && !r_faultReported) begin
                        r_pulseDone     <= 1'b1;
                        r_pulseLen      <= w_cnt;
                        r_lenOk         <= 1'b0;
                        r_badCnt        <= r_badCnt + LASER_MON_CNT_W'(1);
                        r_faultReported <= 1'b1;
                    end
`else
                    if (!light) begin
                        r_pulseDone <= 1'b1;
                        r_pulseLen  <= w_cnt;
                        r_lenOk     <= 1'b0;
                        r_badCnt    <= r_badCnt + LASER_MON_CNT_W'(1);
                        r_laserKill <= 1'b0;
                        r_state     <= IDLE;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pulse_done = r_pulseDone;
    assign pulse_len  = r_pulseLen;
    assign len_ok     = r_lenOk;
    assign laser_kill = r_laserKill;
    assign good_cnt   = r_goodCnt;
    assign bad_cnt    = r_badCnt;

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// tb_laser_pulse_monitor: randomized and directed checks of the laser pulse
// monitor against a run-length reference model. Instance A uses NBITS=16,
// instance B uses NBITS=3 to exercise counter saturation.
module tb_laser_pulse_monitor;

    localparam int P  = 5;
    localparam int T  = 1;
    localparam int LO = P - T;
    localparam int HI = P + T;
`ifdef LASER_MON_STICKY_KILL_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic light = 1'b0;

    logic        pulseDoneA, lenOkA, laserKillA;
    logic [15:0] pulseLenA, goodCntA, badCntA;
    logic        pulseDoneB, lenOkB, laserKillB;
    logic [2:0]  pulseLenB;
    logic [15:0] goodCntB, badCntB;

    int nTotal = 0;
    int nBad   = 0;
    int cyc    = 0;

    // Reference model: length of the current high run, lock-out after a sticky fault
    int          mRun   [2];
    bit          mLock  [2];
    bit          eDone  [2];
    int          eLen   [2];
    bit          eOk    [2];
    bit          eKill  [2];
    logic [15:0] eGood  [2];
    logic [15:0] eBad   [2];
    int          satMax [2] = '{65535, 7};

    laser_pulse_monitor #(.NBITS(16), .PULSE_CYCLES(P), .TOL(T)) dutA (
        .clk        (clk),
        .reset      (reset),
        .light      (light),
        .pulse_done (pulseDoneA),
        .pulse_len  (pulseLenA),
        .len_ok     (lenOkA),
        .laser_kill (laserKillA),
        .good_cnt   (goodCntA),
        .bad_cnt    (badCntA)
    );

    laser_pulse_monitor #(.NBITS(3), .PULSE_CYCLES(P), .TOL(T)) dutB (
        .clk        (clk),
        .reset      (reset),
        .light      (light),
        .pulse_done (pulseDoneB),
        .pulse_len  (pulseLenB),
        .len_ok     (lenOkB),
        .laser_kill (laserKillB),
        .good_cnt   (goodCntB),
        .bad_cnt    (badCntB)
    );

    always #5 clk = ~clk;

    wire [50:0] obsA = {pulseDoneA, pulseLenA, lenOkA, laserKillA, goodCntA, badCntA};
    wire [37:0] obsB = {pulseDoneB, pulseLenB, lenOkB, laserKillB, goodCntB, badCntB};

    function automatic logic [50:0] expA();
        return {eDone[0], 16'(eLen[0]), eOk[0], eKill[0], eGood[0], eBad[0]};
    endfunction

    function automatic logic [37:0] expB();
        return {eDone[1], 3'(eLen[1]), eOk[1], eKill[1], eGood[1], eBad[1]};
    endfunction

    // Advance the model by one sampled edge: a pulse is a run of highs ended by a low
    task automatic modelEdge(input bit l, input bit r);
        for (int i = 0; i < 2; i++) begin
            eDone[i] = 1'b0;
            if (r) begin
                mRun[i] = 0; mLock[i] = 1'b0; eLen[i] = 0; eOk[i] = 1'b0;
                eKill[i] = 1'b0; eGood[i] = '0; eBad[i] = '0;
            end else if (!mLock[i]) begin
                if (l) begin
                    mRun[i]++;
                    if (mRun[i] > HI) eKill[i] = 1'b1;
                end else if (mRun[i] > 0) begin
                    eDone[i] = 1'b1;
                    eLen[i]  = (mRun[i] > satMax[i]) ? satMax[i] : mRun[i];
                    eOk[i]   = (mRun[i] >= LO) && (mRun[i] <= HI);
                    if (eOk[i]) eGood[i] = eGood[i] + 16'd1;
                    else        eBad[i]  = eBad[i] + 16'd1;
                    if (mRun[i] > HI) begin
                        if (STICKY) mLock[i] = 1'b1;
                        else        eKill[i] = 1'b0;
                    end
                    mRun[i] = 0;
                end
            end
        end
    endtask

    task automatic applyStep(input bit l, input bit r);
        @(negedge clk);
        light = l;
        reset = r;
        modelEdge(l, r);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        applyStep(1'b1, 1'b1);
        applyStep(1'b0, 1'b1);
        nTotal++;
        if (obsA !== 51'd0) begin
            nBad++;
            $display("FAIL reset_state_A got=%h want=0", obsA);
        end
        nTotal++;
        if (obsB !== 38'd0) begin
            nBad++;
            $display("FAIL reset_state_B got=%h want=0", obsB);
        end
        applyStep(1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        bit sawKill = 1'b0;
        applyStep(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStep(i < 5, 1'b0);
            if (laserKillA) sawKill = 1'b1;
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL nominal_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
            if (i == 5) begin
                nTotal++;
                if ({pulseDoneA, pulseLenA, lenOkA, goodCntA} !== {1'b1, 16'd5, 1'b1, 16'd1}) begin
                    nBad++;
                    $display("FAIL nominal_report got done=%b len=%0d ok=%b good=%0d want 1/5/1/1",
                             pulseDoneA, pulseLenA, lenOkA, goodCntA);
                end
            end
        end
        nTotal++;
        if (sawKill) begin
            nBad++;
            $display("FAIL nominal_kill got=1 want=0");
        end
    endtask

    task automatic test_short();
        applyStep(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStep(i < 3, 1'b0);
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL short_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
            if (i == 3) begin
                nTotal++;
                if ({pulseDoneA, pulseLenA, lenOkA, laserKillA, badCntA} !== {1'b1, 16'd3, 1'b0, 1'b0, 16'd1}) begin
                    nBad++;
                    $display("FAIL short_report got done=%b len=%0d ok=%b kill=%b bad=%0d want 1/3/0/0/1",
                             pulseDoneA, pulseLenA, lenOkA, laserKillA, badCntA);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int doneSeen = 0;
        applyStep(1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStep(1'b1, 1'b0);
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL overrun_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
            if (i == 6 || i == 7) begin
                nTotal++;
                if (laserKillA !== (i == 7)) begin
                    nBad++;
                    $display("FAIL overrun_kill_edge sample=%0d got=%b want=%b", i, laserKillA, i == 7);
                end
            end
        end
        applyStep(1'b0, 1'b0);
        nTotal++;
        if ({pulseDoneA, pulseLenA, lenOkA, badCntA, laserKillA} !== {1'b1, 16'd10, 1'b0, 16'd1, STICKY}) begin
            nBad++;
            $display("FAIL overrun_report got done=%b len=%0d ok=%b bad=%0d kill=%b want 1/10/0/1/%b",
                     pulseDoneA, pulseLenA, lenOkA, badCntA, laserKillA, STICKY);
        end
        for (int i = 0; i < 8; i++) begin
            applyStep(i >= 1 && i <= 5, 1'b0);
            if (pulseDoneA) doneSeen++;
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL overrun_follow_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
        end
        nTotal++;
        if ({doneSeen, goodCntA, laserKillA} !== {(STICKY ? 0 : 1), (STICKY ? 16'd0 : 16'd1), STICKY}) begin
            nBad++;
            $display("FAIL overrun_follow got dones=%0d good=%0d kill=%b want %0d/%0d/%b",
                     doneSeen, goodCntA, laserKillA, STICKY ? 0 : 1, STICKY ? 0 : 1, STICKY);
        end
    endtask

    task automatic test_saturation();
        applyStep(1'b0, 1'b1);
        for (int i = 1; i <= 11; i++) begin
            applyStep(i <= 10, 1'b0);
            nTotal++;
            if (obsB !== expB()) begin
                nBad++;
                $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, obsB, expB());
            end
            if (i == 7) begin
                nTotal++;
                if (laserKillB !== 1'b1) begin
                    nBad++;
                    $display("FAIL sat_kill got=%b want=1", laserKillB);
                end
            end
        end
        nTotal++;
        if ({pulseDoneB, pulseLenB, pulseLenA} !== {1'b1, 3'd7, 16'd10}) begin
            nBad++;
            $display("FAIL sat_len got done=%b lenB=%0d lenA=%0d want 1/7/10",
                     pulseDoneB, pulseLenB, pulseLenA);
        end
    endtask

    task automatic test_back_to_back();
        int doneCyc[$];
        applyStep(1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            applyStep((i < 5) || (i >= 6 && i < 11), 1'b0);
            if (pulseDoneA) doneCyc.push_back(i);
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
        end
        nTotal++;
        if (doneCyc.size() != 2 || goodCntA !== 16'd2) begin
            nBad++;
            $display("FAIL b2b_count got dones=%0d good=%0d want 2/2", doneCyc.size(), goodCntA);
        end else begin
            nTotal++;
            if (doneCyc[1] - doneCyc[0] != 6) begin
                nBad++;
                $display("FAIL b2b_spacing got=%0d want=6", doneCyc[1] - doneCyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int doneSeen = 0;
        applyStep(1'b0, 1'b1);
        applyStep(1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            applyStep(i <= 7, i == 3);
            if (pulseDoneA) doneSeen++;
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL reset_mid_model cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
        end
        nTotal++;
        if ({doneSeen, pulseLenA, lenOkA, goodCntA, badCntA} !== {1, 16'd4, 1'b1, 16'd1, 16'd0}) begin
            nBad++;
            $display("FAIL reset_mid_report got dones=%0d len=%0d ok=%b good=%0d bad=%0d want 1/4/1/1/0",
                     doneSeen, pulseLenA, lenOkA, goodCntA, badCntA);
        end
    endtask

    task automatic test_random();
        bit lq[$];
        bit rq[$];
        applyStep(1'b0, 1'b1);
        for (int p = 0; p < 60; p++) begin
            int hi  = $urandom_range(1, 9);
            int gap = $urandom_range(0, 2);
            for (int k = 0; k < hi; k++) begin
                lq.push_back(1'b1);
                rq.push_back($urandom_range(0, 39) == 0);
            end
            for (int k = 0; k < gap; k++) begin
                lq.push_back(1'b0);
                rq.push_back(1'b0);
            end
        end
        lq.push_back(1'b0);
        rq.push_back(1'b0);
        for (int i = 0; i < lq.size(); i++) begin
            applyStep(lq[i], rq[i]);
            nTotal++;
            if (obsA !== expA()) begin
                nBad++;
                $display("FAIL random_A cyc=%0d got=%h want=%h", cyc, obsA, expA());
            end
            nTotal++;
            if (obsB !== expB()) begin
                nBad++;
                $display("FAIL random_B cyc=%0d got=%h want=%h", cyc, obsB, expB());
            end
        end
    endtask

    initial begin
        $display("[TB] laser_pulse_monitor bench start, sticky=%0b", STICKY);
        test_reset();
        test_nominal();
        test_short();
        test_overrun();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule

// File: doc/laser_pulse_monitor.md
# laser_pulse_monitor

Receive-side checker for the laser surgery system's `light` output. It measures the duration of every laser-on pulse and reports each pulse's length and whether that length is in tolerance. It keeps good and bad pulse counts. It raises a `laser_kill` request if the laser stays on past the allowed window. It sits beside `laser_surgery_sys` on the same clock and consumes the light line as its only data input.

## Interface
- `NBITS`, 16: width of the pulse-length counter and of `pulse_len`.
- `PULSE_CYCLES`, 5: nominal pulse length in clock cycles.
- `TOL`, 1: allowed deviation in cycles. Legal range is `TOL < PULSE_CYCLES`, and `PULSE_CYCLES+TOL < 2^NBITS-1`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; all state and outputs go to their reset values on the next edge.
- `light`  in  1  laser-on line, synchronous to `clk`, sampled directly with no input flop.
- `pulse_done`  out  1  one-cycle strobe: a pulse has ended. Reset value 0.
- `pulse_len`  out  NBITS  length of the last ended pulse; holds until the next `pulse_done`. Reset value 0.
- `len_ok`  out  1  last pulse length was within `PULSE_CYCLES±TOL`; holds with `pulse_len`. Reset value 0.
- `laser_kill`  out  1  overrun shutdown request. Reset value 0.
- `good_cnt`  out  16  count of in-tolerance pulses; wraps modulo 2^16. Reset value 0.
- `bad_cnt`  out  16  count of out-of-tolerance pulses; wraps modulo 2^16. Reset value 0.

## Operation
The block is a three-state FSM with states IDLE, ON and FAULT. Reset puts it in IDLE with `cnt=0`.

- **IDLE**
  - `light=1`: go to ON, `cnt<=1`.
  - Otherwise: stay in IDLE.
- **ON**
  - `light=1` and `cnt < PULSE_CYCLES+TOL`: `cnt<=cnt+1`, stay in ON.
  - `light=1` and `cnt == PULSE_CYCLES+TOL`: go to FAULT, `laser_kill<=1`, `cnt<=cnt+1`.
  - `light=0`: end the pulse (see below) and go to IDLE.
- **FAULT**
  - `light=1`: `cnt` keeps counting and saturates at 2^NBITS-1.
  - `light=0`: end the pulse with `len_ok<=0` forced; the next state is set by the configuration macro.
- **Pulse end** updates all of the following on the same edge:
  - `pulse_done<=1`
  - `pulse_len<=cnt`
  - `len_ok<=(PULSE_CYCLES-TOL <= cnt <= PULSE_CYCLES+TOL)`
  - `good_cnt` or `bad_cnt` increments by 1
  - `cnt<=0`
- **Arithmetic:** `cnt` is an unsigned NBITS saturating counter. The tolerance bounds are compile-time constants, and the comparisons are unsigned.

## Timing
- **Pulse report latency:** `light` sampled high on N consecutive edges, then low on edge N+1. `pulse_done=1` in the cycle following edge N+1, with `pulse_len=N`.
- **Kill latency:** `laser_kill` rises in the cycle after the (PULSE_CYCLES+TOL+1)-th consecutive high sample.
- **Back-to-back pulses:** one low sample between two pulses is sufficient. In IDLE, the first high sample starts a new pulse, and the previous pulse's `pulse_done` may be high in that same cycle. Zero low samples means one continuous pulse.
- **Reset mid-pulse:** the partial pulse is discarded, with no `pulse_done` and no count. If `light` is still high on the first edge after `reset` falls, that edge starts a new pulse.
- **Reset priority:** `reset` has priority over every transition, including a pulse end on the same edge.
- **Counter wrap:** `good_cnt` and `bad_cnt` wrap 0xFFFF→0 with no flag.

## Configuration
`LASER_MON_STICKY_KILL_EN` selects what happens after an overrun:

- **Defined:** FAULT exits only on `reset`, and `laser_kill` stays 1. The faulted pulse still reports once when `light` falls. After that, further pulses are ignored: no `pulse_done` and no count changes.
- **Undefined:** when `light` falls in FAULT, the FSM goes to IDLE and `laser_kill<=0` on the same edge as `pulse_done`.

## Structure
- **Package `laser_mon_pkg`:**
  - state enum typedef `laser_mon_state_t` with values IDLE, ON, FAULT
  - constant `LASER_MON_CNT_W=16` for the good and bad counters
- **Sub-module `laser_mon_sat_cnt`:** parameterised NBITS saturating up-counter with synchronous clear and increment enable, used for `cnt`. The FSM, compares and event counters stay in the top module.

## Test plan
All scenarios use PULSE_CYCLES=5 and TOL=1.

- **Nominal pulse:** `light` high for 5 edges, then low → one `pulse_done`, `pulse_len=5`, `len_ok=1`, `good_cnt=1`, `laser_kill=0` throughout.
- **Short pulse:** `light` high for 3 edges → `pulse_len=3`, `len_ok=0`, `bad_cnt=1`, no kill.
- **Overrun:** `light` high for 10 edges → `laser_kill=1` from the cycle after the 7th high sample. On fall: `pulse_len=10`, `len_ok=0`, `bad_cnt=1`. Without the macro, `laser_kill` returns to 0 with `pulse_done`. With the macro, `laser_kill` stays 1, and a subsequent 5-cycle pulse produces no `pulse_done` and leaves `good_cnt=0`.
- **Back-to-back:** two 5-cycle pulses with one low cycle between them → two `pulse_done` strobes 6 cycles apart, `good_cnt=2`.
- **Reset mid-pulse:** `reset` held for 1 cycle at the 3rd high sample, then `light` stays high for 4 more edges and falls → exactly one `pulse_done`, `pulse_len=4`, `len_ok=1`, `good_cnt=1`.
- **Saturation:** with NBITS=3 and `light` high for 10 edges → `laser_kill` asserts after the 7th high sample, and `pulse_len=7` (saturated).
